// File: rtl/bch_decode_scheduler.sv
// BCH(15,7,t=2) decode sequencer: round-robin intake from two requesters, registered
// syndrome and locator stages, serial 15-step Chien search, and a held result port.
module bch_decode_scheduler #(
  parameter bit SKIP_CLEAN = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [1:0][14:0] req_cw,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_tag,
  output logic [14:0]      out_cw,
  output logic [6:0]       out_msg,
  output logic [1:0]       out_nerr,
  output logic             out_fail,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_decoded,
  output logic [CNT_W-1:0] cnt_failed
);

  typedef enum logic [2:0] {IDLE, SYND, LOC, SEARCH, DONE} state_t;

  localparam logic [3:0] ALPHA [0:14] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                          4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
    end
    return p;
  endfunction

  // a^14 == a^-1 in GF(16); maps 0 to 0, which never matters since num/0 is not taken.
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf_mul(a, a);
    a4 = gf_mul(a2, a2);
    a8 = gf_mul(a4, a4);
    return gf_mul(gf_mul(a8, a4), a2);
  endfunction

  state_t state_reg, state_next;
  logic [1:0]  grant;
  logic        last_reg, tag_reg, lfail_reg;
  logic [14:0] rx_reg, mask_reg;
  logic [3:0]  s1_reg, s3_reg, sigma1_reg, sigma2_reg, step_reg;
  logic [1:0]  exp_reg, roots_reg;

  logic [3:0] s1_term [15];
  logic [3:0] s3_term [15];
  logic [3:0] s1_calc, s3_calc, num_calc, sigma2_calc, neg_pow, chien_eval;
  logic [3:0] neg_idx;
  logic       clean_calc, lfail_calc, done_fail;

  for (genvar gi = 0; gi < 15; gi++) begin : g_synd
    assign s1_term[gi] = rx_reg[gi] ? ALPHA[gi] : 4'h0;
    assign s3_term[gi] = rx_reg[gi] ? ALPHA[(3 * gi) % 15] : 4'h0;
  end

  always_comb begin
    s1_calc = 4'h0;
    s3_calc = 4'h0;
    for (int k = 0; k < 15; k++) begin
      s1_calc = s1_calc ^ s1_term[k];
      s3_calc = s3_calc ^ s3_term[k];
    end
  end

  always_comb begin
    num_calc    = s3_reg ^ gf_mul(s1_reg, gf_mul(s1_reg, s1_reg));
    sigma2_calc = (num_calc == 4'h0) ? 4'h0 : gf_mul(num_calc, gf_inv(s1_reg));
    clean_calc  = (s1_reg == 4'h0) && (s3_reg == 4'h0);
    lfail_calc  = (s1_reg == 4'h0) && (s3_reg != 4'h0);
  end

  // sigma(x) evaluated at alpha^-i; a zero marks bit i as an error position.
  always_comb begin
    neg_idx    = (step_reg == 4'd0) ? 4'd0 : 4'd15 - step_reg;
    neg_pow    = ALPHA[neg_idx];
    chien_eval = 4'h1 ^ gf_mul(sigma1_reg, neg_pow) ^ gf_mul(sigma2_reg, gf_mul(neg_pow, neg_pow));
    done_fail  = lfail_reg || (roots_reg != exp_reg);
  end

  always_comb begin
    grant = 2'b00;
    if (state_reg == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_reg ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    req_ready = grant;
    busy      = (state_reg != IDLE);
    out_msg   = out_cw[14:8];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant != 2'b00) state_next = SYND;
      SYND:    state_next = LOC;
      LOC:     state_next = (SKIP_CLEAN && (clean_calc || lfail_calc)) ? DONE : SEARCH;
      SEARCH:  if (step_reg == 4'd14) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      tag_reg     <= 1'b0;
      rx_reg      <= '0;
      s1_reg      <= '0;
      s3_reg      <= '0;
      sigma1_reg  <= '0;
      sigma2_reg  <= '0;
      exp_reg     <= '0;
      lfail_reg   <= 1'b0;
      step_reg    <= '0;
      roots_reg   <= '0;
      mask_reg    <= '0;
      out_valid   <= 1'b0;
      out_tag     <= 1'b0;
      out_cw      <= '0;
      out_nerr    <= '0;
      out_fail    <= 1'b0;
      cnt_decoded <= '0;
      cnt_failed  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant != 2'b00) begin
            rx_reg   <= req_cw[grant[1]];
            tag_reg  <= grant[1];
            last_reg <= grant[1];
          end
        end
        SYND: begin
          s1_reg <= s1_calc;
          s3_reg <= s3_calc;
        end
        LOC: begin
          sigma1_reg <= s1_reg;
          sigma2_reg <= sigma2_calc;
          exp_reg    <= clean_calc ? 2'd0 : ((sigma2_calc == 4'h0) ? 2'd1 : 2'd2);
          lfail_reg  <= lfail_calc;
          step_reg   <= '0;
          roots_reg  <= '0;
          mask_reg   <= '0;
        end
        SEARCH: begin
          if (chien_eval == 4'h0) begin
            mask_reg[step_reg] <= 1'b1;
            if (roots_reg != 2'd3) roots_reg <= roots_reg + 2'd1;
          end
          step_reg <= step_reg + 4'd1;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_tag   <= tag_reg;
            out_fail  <= done_fail;
            out_cw    <= done_fail ? rx_reg : (rx_reg ^ mask_reg);
            out_nerr  <= done_fail ? 2'd0 : roots_reg;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt_decoded != {CNT_W{1'b1}}) cnt_decoded <= cnt_decoded + CNT_W'(1);
            if (out_fail && (cnt_failed != {CNT_W{1'b1}})) cnt_failed <= cnt_failed + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_decode_scheduler.sv
// Scoreboarded bench for bch_decode_scheduler: nearest-codeword reference model,
// directed vectors, randomized two-requester traffic with back-pressure, mid-decode reset.
module tb_bch_decode_scheduler;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][14:0] req_cw;
  logic [1:0]       req_ready;
  logic             out_valid, out_ready, out_tag, out_fail, busy;
  logic [14:0]      out_cw;
  logic [6:0]       out_msg;
  logic [1:0]       out_nerr;
  logic [15:0]      cnt_decoded, cnt_failed;

  bch_decode_scheduler #(.SKIP_CLEAN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cw(req_cw), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_cw(out_cw),
    .out_msg(out_msg), .out_nerr(out_nerr), .out_fail(out_fail), .busy(busy),
    .cnt_decoded(cnt_decoded), .cnt_failed(cnt_failed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tag;
    logic [14:0] cw;
    logic [1:0]  nerr;
    logic        fail;
    int          hs;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  logic [14:0] cbook [128];
  logic [3:0]  alpha_t [15];
  logic [1:0]  hs_flag = 2'b00;
  bit          in_flight = 1'b0;
  bit          last = 1'b1;
  bit          held = 1'b0;
  int          m_dec = 0;
  int          m_fail = 0;
  bit          cur_fail;
  logic [25:0] snap;

  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Codewords are all multiples of g(x) = x^8+x^7+x^6+x^4+1.
  function automatic logic [14:0] clmul(input logic [6:0] m);
    logic [14:0] p;
    p = '0;
    for (int k = 0; k < 7; k++) if (m[k]) p = p ^ (15'h01D1 << k);
    return p;
  endfunction

  // Bounded-distance decode: the unique codeword within distance 2, else failure.
  function automatic exp_t model(input logic tag, input logic [14:0] rx);
    exp_t e;
    logic [3:0] s1;
    e.tag = tag; e.cw = rx; e.nerr = 2'd0; e.fail = 1'b1; e.hs = 0;
    for (int m = 0; m < 128; m++) begin
      int d;
      d = $countones(rx ^ cbook[m]);
      if (d <= 2) begin
        e.cw = cbook[m]; e.nerr = 2'(d); e.fail = 1'b0;
      end
    end
    s1 = 4'h0;
    for (int i = 0; i < 15; i++) if (rx[i]) s1 = s1 ^ alpha_t[i];
    e.lat = (s1 == 4'h0) ? 3 : 18;
    return e;
  endfunction

  function automatic logic [14:0] gen_word();
    logic [14:0] w;
    int nf, b;
    if ($urandom_range(0, 7) == 0) return 15'($urandom);
    w = cbook[$urandom_range(0, 127)];
    nf = int'($urandom_range(0, 3));
    for (int k = 0; k < nf; k++) begin
      b = int'($urandom_range(0, 14));
      w[b] = ~w[b];
    end
    return w;
  endfunction

  // Monitor: grant/busy model, result scoreboard, hold stability, counters.
  always @(negedge clk) begin
    logic [1:0] exp_ready, hs;
    exp_t e;
    if (rst) begin
      sb.delete();
      in_flight = 1'b0; last = 1'b1; held = 1'b0; hs_flag = 2'b00;
      m_dec = 0; m_fail = 0;
    end else begin
      exp_ready = 2'b00;
      if (!in_flight) begin
        case (req_valid)
          2'b01:   exp_ready = 2'b01;
          2'b10:   exp_ready = 2'b10;
          2'b11:   exp_ready = last ? 2'b01 : 2'b10;
          default: exp_ready = 2'b00;
        endcase
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(in_flight));
      if (out_valid) begin
        if (!held) begin
          if (sb.size() == 0) begin
            chk("pending_results", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("out_tag", 32'(out_tag), 32'(e.tag));
            chk("out_cw", 32'(out_cw), 32'(e.cw));
            chk("out_msg", 32'(out_msg), 32'(e.cw[14:8]));
            chk("out_nerr", 32'(out_nerr), 32'(e.nerr));
            chk("out_fail", 32'(out_fail), 32'(e.fail));
            chk("latency", 32'(cycle - e.hs), 32'(e.lat));
            chk("cnt_decoded", 32'(cnt_decoded), 32'(m_dec));
            chk("cnt_failed", 32'(cnt_failed), 32'(m_fail));
            snap = {out_tag, out_cw, out_msg, out_nerr, out_fail};
            cur_fail = e.fail;
          end
        end else begin
          chk("hold_stable", 32'({out_tag, out_cw, out_msg, out_nerr, out_fail}), 32'(snap));
        end
        if (out_ready) begin
          m_dec++;
          if (cur_fail) m_fail++;
          in_flight = 1'b0;
        end
      end
      held = out_valid && !out_ready;
      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        e = model(hs[1], req_cw[hs[1]]);
        e.hs = cycle + 1;
        $display("issue tag=%0d rx=%04h exp_cw=%04h nerr=%0d fail=%0d lat=%0d",
                 e.tag, req_cw[hs[1]], e.cw, e.nerr, e.fail, e.lat);
        sb.push_back(e);
        last = hs[1];
        in_flight = 1'b1;
        hs_flag[hs[1]] = 1'b1;
      end
    end
  end

  task automatic wait_hs(input int r);
    int k;
    k = 0;
    while (!hs_flag[r] && k < 100) begin @(posedge clk); k++; end
    chk("grant_timeout", 32'(hs_flag[r]), 32'd1);
    #1;
    hs_flag[r] = 1'b0;
    req_valid[r] = 1'b0;
  endtask

  task automatic issue(input int r, input logic [14:0] w);
    req_valid[r] = 1'b1;
    req_cw[r] = w;
    wait_hs(r);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((in_flight || sb.size() != 0) && k < 200) begin @(posedge clk); k++; end
    chk("idle_in_flight", 32'(in_flight), 32'd0);
    chk("idle_pending", 32'(sb.size()), 32'd0);
    #1;
  endtask

  task automatic traffic(input int ncyc, input bit always_valid, input int ready_pct);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (hs_flag[r]) begin hs_flag[r] = 1'b0; req_valid[r] = 1'b0; end
        if (!req_valid[r] && (always_valid || $urandom_range(0, 3) != 0)) begin
          req_valid[r] = 1'b1;
          req_cw[r] = gen_word();
        end
      end
      out_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
    @(posedge clk); #1;
    hs_flag = 2'b00;
    req_valid = 2'b00;
    out_ready = 1'b1;
    wait_idle();
  endtask

  initial begin
    int k;
    alpha_t = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
    for (int m = 0; m < 128; m++) cbook[m] = clmul(7'(m));
    rst = 1'b1; req_valid = 2'b00; req_cw = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_cw", 32'(out_cw), 32'd0);
    chk("rst_out_msg", 32'(out_msg), 32'd0);
    chk("rst_out_nerr", 32'(out_nerr), 32'd0);
    chk("rst_out_fail", 32'(out_fail), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt_decoded", 32'(cnt_decoded), 32'd0);
    chk("rst_cnt_failed", 32'(cnt_failed), 32'd0);
    @(posedge clk); #1;

    // Directed words: clean, one error, two errors on requester 1, S1=0 failure.
    issue(0, 15'h01D1); wait_idle();
    issue(0, 15'h05D1); wait_idle();
    issue(1, 15'h41D0); wait_idle();
    issue(0, 15'h0013); wait_idle();

    // Back-pressure: result held 5 cycles while requester 1 waits ungranted.
    out_ready = 1'b0;
    issue(0, 15'h05D1);
    req_valid[1] = 1'b1; req_cw[1] = 15'h41D0;
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    chk("hold_seen_valid", 32'(out_valid), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_hs(1);
    wait_idle();

    traffic(400, 1'b0, 75);
    traffic(300, 1'b1, 30);

    // Reset in the middle of SEARCH: word discarded, counters cleared.
    issue(0, 15'h05D1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt_decoded", 32'(cnt_decoded), 32'd0);
    chk("midrst_cnt_failed", 32'(cnt_failed), 32'd0);
    @(posedge clk); #1;
    issue(0, 15'h41D0); wait_idle();
    @(negedge clk);
    chk("final_cnt_decoded", 32'(cnt_decoded), 32'(m_dec));
    chk("final_cnt_failed", 32'(cnt_failed), 32'(m_fail));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
